// File: rtl/if_fetch_queue.sv
// Instruction fetch stage: issues ISSUE_W-word fetch groups and buffers the returned
// words with their PCs in a circular queue that feeds ID. Handles redirects and misaligned PCs.
module if_fetch_queue #(
  parameter int unsigned ISSUE_W  = 2,
  parameter int unsigned QDEPTH   = 8,
  parameter logic [31:0] RESET_PC = 32'hbfc0_0000,
  parameter logic [31:0] EXC_VEC  = 32'hbfc0_0380,
  localparam int unsigned PW = $clog2(ISSUE_W + 1),
  localparam int unsigned CW = $clog2(QDEPTH + 1)
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   exc_valid_i,
  input  logic                   br_valid_i,
  input  logic [31:0]            br_target_i,
  output logic                   imem_req_o,
  output logic [31:0]            imem_addr_o,
  input  logic                   imem_gnt_i,
  input  logic                   imem_rvalid_i,
  input  logic [32*ISSUE_W-1:0]  imem_rdata_i,
  output logic [ISSUE_W-1:0]     id_valid_o,
  output logic [32*ISSUE_W-1:0]  id_inst_o,
  output logic [32*ISSUE_W-1:0]  id_pc_o,
  output logic [ISSUE_W-1:0]     id_adel_o,
  input  logic [PW-1:0]          id_pop_i,
  output logic [CW-1:0]          q_count_o
);
  localparam int unsigned AW  = $clog2(QDEPTH);
  localparam int unsigned CW1 = CW + 1;

  // Handshake: imem_req_o/imem_addr_o are held until imem_gnt_i is seen high at a rising
  // edge; the single outstanding response returns as a one-cycle imem_rvalid_i pulse.
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_HALT} state_t;

  state_t          state_q, state_d;
  logic [31:0]     pc_q, pc_d, fpc_q, fpc_d;
  logic            drop_q, drop_d, adel_done_q, adel_done_d;
  logic [AW-1:0]   head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]   count_q, count_d, pop_req, pop_n, push_n;
  logic [CW:0]     free_w;
  logic            redirect, wr_grp, wr_adel;
  logic [31:0]     redir_pc;
  logic [AW-1:0]   wr_idx [ISSUE_W];
  logic [AW-1:0]   rd_idx [ISSUE_W];
  logic [31:0]     inst_mem [QDEPTH];
  logic [31:0]     pc_mem   [QDEPTH];
  logic [QDEPTH-1:0] adel_mem;

  assign redirect = exc_valid_i | br_valid_i;
  assign redir_pc = exc_valid_i ? EXC_VEC : br_target_i;
  assign pop_req  = CW'(id_pop_i);
  assign pop_n    = (pop_req > count_q) ? count_q : pop_req;
  assign free_w   = CW1'(QDEPTH) - {1'b0, count_q} + {1'b0, pop_n};

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    fpc_d       = fpc_q;
    drop_d      = drop_q;
    adel_done_d = adel_done_q;
    wr_grp      = 1'b0;
    wr_adel     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pc_q[1:0] != 2'b00) begin
          state_d     = S_HALT;
          adel_done_d = 1'b0;
        end else if (free_w >= CW1'(ISSUE_W)) begin
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (imem_gnt_i) begin
          fpc_d   = pc_q;
          pc_d    = pc_q + 32'(4 * ISSUE_W);
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_rvalid_i) begin
          wr_grp  = ~drop_q;
          drop_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      S_HALT: begin
        if (!adel_done_q && (count_q - pop_n) < CW'(QDEPTH)) begin
          wr_adel     = 1'b1;
          adel_done_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // A request the memory already owns must still be answered; remember to discard it.
    if (redirect) begin
      pc_d    = redir_pc;
      wr_grp  = 1'b0;
      wr_adel = 1'b0;
      if ((state_q == S_REQ && imem_gnt_i) || (state_q == S_WAIT && !imem_rvalid_i)) begin
        state_d = S_WAIT;
        drop_d  = 1'b1;
      end else if (redir_pc[1:0] != 2'b00) begin
        state_d     = S_HALT;
        adel_done_d = 1'b0;
        drop_d      = 1'b0;
      end else if (state_q == S_REQ || state_q == S_WAIT) begin
        state_d = S_IDLE;
        drop_d  = 1'b0;
      end else begin
        state_d = S_REQ;
      end
    end
  end

  always_comb begin
    push_n = wr_grp ? CW'(ISSUE_W) : (wr_adel ? CW'(1) : '0);
    if (redirect) begin
      head_d  = tail_q;
      tail_d  = tail_q;
      count_d = '0;
    end else begin
      head_d  = head_q + pop_n[AW-1:0];
      tail_d  = tail_q + push_n[AW-1:0];
      count_d = count_q + push_n - pop_n;
    end
  end

  always_comb begin
    for (int i = 0; i < ISSUE_W; i++) begin
      wr_idx[i] = tail_q + AW'(i);
      rd_idx[i] = head_q + AW'(i);
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= S_IDLE;
      pc_q        <= RESET_PC;
      fpc_q       <= RESET_PC;
      drop_q      <= 1'b0;
      adel_done_q <= 1'b0;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      fpc_q       <= fpc_d;
      drop_q      <= drop_d;
      adel_done_q <= adel_done_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
    end
  end

  // Queue storage needs no reset: slots are only observed while covered by count_q.
  always_ff @(posedge clk_i) begin
    if (wr_grp) begin
      for (int i = 0; i < ISSUE_W; i++) begin
        inst_mem[wr_idx[i]] <= imem_rdata_i[32*i +: 32];
        pc_mem[wr_idx[i]]   <= fpc_q + 32'(4 * i);
        adel_mem[wr_idx[i]] <= 1'b0;
      end
    end else if (wr_adel) begin
      inst_mem[tail_q] <= 32'h0;
      pc_mem[tail_q]   <= pc_q;
      adel_mem[tail_q] <= 1'b1;
    end
  end

  always_comb begin
    id_valid_o = '0;
    id_inst_o  = '0;
    id_pc_o    = '0;
    id_adel_o  = '0;
    for (int i = 0; i < ISSUE_W; i++) begin
      id_valid_o[i]         = count_q > CW'(i);
      id_inst_o[32*i +: 32] = inst_mem[rd_idx[i]];
      id_pc_o[32*i +: 32]   = pc_mem[rd_idx[i]];
      id_adel_o[i]          = adel_mem[rd_idx[i]] & id_valid_o[i];
    end
  end

  assign imem_req_o  = (state_q == S_REQ);
  assign imem_addr_o = pc_q;
  assign q_count_o   = count_q;

endmodule
